// File: rtl/uart_rx_frame_ctrl.sv
// Frame sequencer behind the UART receiver: parses HDR0 HDR1 CMD LEN payload CHK,
// forwards payload bytes and reports each frame's outcome with a done pulse.
module uart_rx_frame_ctrl #(
  parameter logic [7:0]  P_HDR0           = 8'h55,
  parameter logic [7:0]  P_HDR1           = 8'hAA,
  parameter int unsigned P_MAX_LEN        = 64,
  parameter int unsigned P_TIMEOUT_CYCLES = 100_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic [7:0] o_payload_data,
  output logic       o_payload_valid,
  output logic       o_payload_last,
  output logic [7:0] o_frame_cmd,
  output logic [7:0] o_frame_len,
  output logic       o_frame_done,
  output logic [1:0] o_frame_err,
  output logic       o_busy
);

  localparam int unsigned TO_W = $clog2(P_TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(P_TIMEOUT_CYCLES - 1);
  localparam logic [7:0] MAX_LEN = 8'(P_MAX_LEN);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_CHK     = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR1,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHK
  } state_t;

  state_t          state;
  logic [7:0]      sum;
  logic [7:0]      pay_cnt;
  logic [TO_W-1:0] to_cnt;

  // A received byte always takes priority over an expiring inter-byte timeout.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= S_IDLE;
      sum             <= '0;
      pay_cnt         <= '0;
      to_cnt          <= '0;
      o_payload_data  <= '0;
      o_payload_valid <= 1'b0;
      o_payload_last  <= 1'b0;
      o_frame_cmd     <= '0;
      o_frame_len     <= '0;
      o_frame_done    <= 1'b0;
      o_frame_err     <= ERR_OK;
      o_busy          <= 1'b0;
    end else begin
      o_payload_valid <= 1'b0;
      o_payload_last  <= 1'b0;
      o_frame_done    <= 1'b0;

      if (i_rx_valid) begin
        to_cnt <= '0;
        case (state)
          S_IDLE: begin
            if (i_rx_data == P_HDR0) begin
              state  <= S_HDR1;
              o_busy <= 1'b1;
            end
          end

          S_HDR1: begin
            if (i_rx_data == P_HDR1) begin
              state <= S_CMD;
            end else if (i_rx_data != P_HDR0) begin
              state  <= S_IDLE;
              o_busy <= 1'b0;
            end
          end

          S_CMD: begin
            o_frame_cmd <= i_rx_data;
            sum         <= i_rx_data;
            state       <= S_LEN;
          end

          S_LEN: begin
            o_frame_len <= i_rx_data;
            sum         <= sum + i_rx_data;
            pay_cnt     <= '0;
            if (i_rx_data > MAX_LEN) begin
              o_frame_done <= 1'b1;
              o_frame_err  <= ERR_LEN;
              state        <= S_IDLE;
              o_busy       <= 1'b0;
            end else if (i_rx_data == 8'd0) begin
              state <= S_CHK;
            end else begin
              state <= S_PAYLOAD;
            end
          end

          // Payload goes out before the checksum is known; err tells the consumer to drop it.
          S_PAYLOAD: begin
            o_payload_data  <= i_rx_data;
            o_payload_valid <= 1'b1;
            sum             <= sum + i_rx_data;
            pay_cnt         <= pay_cnt + 8'd1;
            if (pay_cnt == o_frame_len - 8'd1) begin
              o_payload_last <= 1'b1;
              state          <= S_CHK;
            end
          end

          S_CHK: begin
            o_frame_done <= 1'b1;
            o_frame_err  <= (i_rx_data == sum) ? ERR_OK : ERR_CHK;
            state        <= S_IDLE;
            o_busy       <= 1'b0;
          end

          default: begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end else if (state == S_IDLE) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_LAST) begin
        to_cnt       <= '0;
        o_frame_done <= 1'b1;
        o_frame_err  <= ERR_TIMEOUT;
        state        <= S_IDLE;
        o_busy       <= 1'b0;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: directed frames from the test plan followed by
// random frames, all checked against a frame-level reference model.
module tb_uart_rx_frame_ctrl;

  localparam int         T    = 50;
  localparam logic [7:0] MAXL = 8'd64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;

  logic [7:0] payload_data;
  logic       payload_valid;
  logic       payload_last;
  logic [7:0] frame_cmd;
  logic [7:0] frame_len;
  logic       frame_done;
  logic [1:0] frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Reference model: bytes after a header pair are collected and interpreted by position.
  bit         m_seen0;
  bit         m_in_body;
  logic [7:0] m_body[$];
  logic       m_pv, m_last, m_done, m_busy;
  logic [7:0] m_pdata, m_cmd, m_len;
  logic [1:0] m_err;

  logic [7:0] tx_q[$];

  uart_rx_frame_ctrl #(
    .P_HDR0(8'h55),
    .P_HDR1(8'hAA),
    .P_MAX_LEN(64),
    .P_TIMEOUT_CYCLES(T)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rx_data(rx_data),
    .i_rx_valid(rx_valid),
    .o_payload_data(payload_data),
    .o_payload_valid(payload_valid),
    .o_payload_last(payload_last),
    .o_frame_cmd(frame_cmd),
    .o_frame_len(frame_len),
    .o_frame_done(frame_done),
    .o_frame_err(frame_err),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    m_seen0   = 1'b0;
    m_in_body = 1'b0;
    m_body.delete();
    m_pv = 1'b0; m_last = 1'b0; m_done = 1'b0; m_busy = 1'b0;
    m_pdata = 8'h00; m_cmd = 8'h00; m_len = 8'h00; m_err = 2'd0;
  endfunction

  function automatic void modelByte(input logic [7:0] b);
    int n;
    int len;
    logic [7:0] s;
    m_pv = 1'b0; m_last = 1'b0; m_done = 1'b0;
    if (m_in_body) begin
      m_body.push_back(b);
      n = m_body.size();
      if (n == 1) begin
        m_cmd = b;
      end else if (n == 2) begin
        m_len = b;
        if (b > MAXL) begin
          m_done = 1'b1; m_err = 2'd2; m_in_body = 1'b0;
        end
      end else begin
        len = int'(m_body[1]);
        if (n <= len + 2) begin
          m_pv = 1'b1; m_pdata = b; m_last = (n == len + 2);
        end else begin
          s = 8'h00;
          for (int i = 0; i < n - 1; i++) s = s + m_body[i];
          m_done = 1'b1;
          m_err = (b == s) ? 2'd0 : 2'd1;
          m_in_body = 1'b0;
        end
      end
    end else if (m_seen0) begin
      if (b == 8'hAA) begin
        m_seen0 = 1'b0; m_in_body = 1'b1; m_body.delete();
      end else if (b != 8'h55) begin
        m_seen0 = 1'b0;
      end
    end else if (b == 8'h55) begin
      m_seen0 = 1'b1;
    end
    m_busy = m_seen0 || m_in_body;
  endfunction

  task automatic checkAll(input string ctx);
    checkOutput({ctx, ".valid"}, payload_valid, m_pv);
    checkOutput({ctx, ".last"}, payload_last, m_last);
    if (m_pv) checkOutput({ctx, ".data"}, payload_data, m_pdata);
    checkOutput({ctx, ".done"}, frame_done, m_done);
    checkOutput({ctx, ".err"}, frame_err, m_err);
    checkOutput({ctx, ".cmd"}, frame_cmd, m_cmd);
    checkOutput({ctx, ".len"}, frame_len, m_len);
    checkOutput({ctx, ".busy"}, busy, m_busy);
  endtask

  // Called at a falling edge; the byte is sampled on the next rising edge and
  // is followed by 'gap' idle cycles. Timeout expected exactly T cycles later.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    bit was_busy;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    modelByte(b);
    checkAll("byte");
    was_busy = m_busy;
    for (int k = 1; k <= gap; k++) begin
      @(negedge clk);
      m_pv = 1'b0; m_last = 1'b0; m_done = 1'b0;
      if (was_busy && k == T) begin
        m_done = 1'b1; m_err = 2'd3;
        m_seen0 = 1'b0; m_in_body = 1'b0; m_busy = 1'b0;
      end
      checkOutput("idle.done", frame_done, m_done);
      checkOutput("idle.busy", busy, m_busy);
      checkOutput("idle.valid", payload_valid, 1'b0);
      if (was_busy && k == T) checkOutput("timeout.err", frame_err, m_err);
    end
  endtask

  task automatic sendQueue(input int count, input int tail);
    for (int i = 0; i < count; i++)
      applyStimulus(tx_q[i], (i == count - 1) ? tail : int'($urandom_range(0, 2)));
  endtask

  task automatic checkZero(input string ctx);
    checkOutput({ctx, ".valid"}, payload_valid, 1'b0);
    checkOutput({ctx, ".last"}, payload_last, 1'b0);
    checkOutput({ctx, ".data"}, payload_data, 8'h00);
    checkOutput({ctx, ".done"}, frame_done, 1'b0);
    checkOutput({ctx, ".err"}, frame_err, 2'd0);
    checkOutput({ctx, ".cmd"}, frame_cmd, 8'h00);
    checkOutput({ctx, ".len"}, frame_len, 8'h00);
    checkOutput({ctx, ".busy"}, busy, 1'b0);
  endtask

  initial begin
    int sel;
    int ln;
    int cut;
    logic [7:0] c;
    logic [7:0] p;
    logic [7:0] s;

    $display("[TB] start");
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkZero("reset");
    rst = 1'b0;
    modelReset();
    @(negedge clk);

    // Good frame, then the same frame with a bad checksum.
    tx_q = '{8'h55, 8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19};
    sendQueue(tx_q.size(), 2);
    tx_q = '{8'h55, 8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h18};
    sendQueue(tx_q.size(), 1);

    // Zero-length frame and an over-length LEN.
    tx_q = '{8'h55, 8'hAA, 8'h22, 8'h00, 8'h22};
    sendQueue(tx_q.size(), 0);
    tx_q = '{8'h55, 8'hAA, 8'h22, 8'h41};
    sendQueue(tx_q.size(), 3);

    // Header resynchronisation.
    tx_q = '{8'h55, 8'h55, 8'hAA, 8'h10, 8'h01, 8'h07, 8'h18};
    sendQueue(tx_q.size(), 1);
    tx_q = '{8'h55, 8'h12, 8'h55, 8'hAA, 8'h10, 8'h01, 8'h07, 8'h18};
    sendQueue(tx_q.size(), 1);

    // Silence after a partial frame, then a byte landing on the timeout cycle.
    tx_q = '{8'h55, 8'hAA, 8'h10, 8'h02, 8'h01};
    sendQueue(tx_q.size(), T + 3);
    applyStimulus(8'h55, 0);
    applyStimulus(8'hAA, 0);
    applyStimulus(8'h10, 0);
    applyStimulus(8'h02, 0);
    applyStimulus(8'h01, T - 1);
    applyStimulus(8'h02, T - 1);
    applyStimulus(8'h15, 2);

    // Reset in the middle of a payload, then a clean frame.
    tx_q = '{8'h55, 8'hAA, 8'h10, 8'h05, 8'h01, 8'h02};
    sendQueue(tx_q.size(), 0);
    #2 rst = 1'b1;
    #1 checkZero("midreset");
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("postreset.done", frame_done, 1'b0);
      checkOutput("postreset.busy", busy, 1'b0);
    end
    tx_q = '{8'h55, 8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h19};
    sendQueue(tx_q.size(), 1);

    // Random frames: good, corrupted checksum, over-length, truncated by timeout.
    for (int f = 0; f < 40; f++) begin
      tx_q.delete();
      if ($urandom_range(0, 3) == 0) tx_q.push_back(8'($urandom));
      tx_q.push_back(8'h55);
      tx_q.push_back(8'hAA);
      c = 8'($urandom);
      tx_q.push_back(c);
      sel = int'($urandom_range(0, 9));
      ln  = (sel == 0) ? int'($urandom_range(65, 255)) : int'($urandom_range(0, 6));
      tx_q.push_back(8'(ln));
      s = c + 8'(ln);
      if (sel != 0) begin
        for (int i = 0; i < ln; i++) begin
          p = 8'($urandom);
          tx_q.push_back(p);
          s = s + p;
        end
        tx_q.push_back((sel == 1) ? s + 8'(1 + $urandom_range(0, 254)) : s);
      end
      if (sel == 2) begin
        cut = int'($urandom_range(1, tx_q.size() - 1));
        sendQueue(cut, T + int'($urandom_range(0, 3)));
      end else begin
        sendQueue(tx_q.size(), int'($urandom_range(0, 3)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
